// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive front end.
package uart_pkg;

    // 10 MHz system clock / 115200 baud
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 87;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous pin inputs.
// Both stages reset to RST_VAL so the idle level is presented at once.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_d;
    logic meta_q;
    logic sync_d;
    logic sync_q;

    // Next values of the two synchronizer stages
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer stages with synchronous reset to the idle level
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver with a one-entry holding register towards the core.
// The start bit is re-checked at mid-bit, data bits are sampled one bit
// period apart from there, and a low stop bit reports a framing error and
// parks the receiver until the line returns high.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       err_clr,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_s;

    rx_state_t        state_d;
    rx_state_t        state_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_d;
    logic [2:0]       idx_q;
    logic [7:0]       shift_d;
    logic [7:0]       shift_q;

    logic             byte_done_s;
    logic             stop_bad_s;
    logic             consume_s;
    logic             drop_s;

    logic [7:0]       data_out_d;
    logic [7:0]       data_out_q;
    logic             data_valid_d;
    logic             data_valid_q;
    logic             frame_err_d;
    logic             frame_err_q;
    logic             overrun_d;
    logic             overrun_q;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

    // Receiver state, bit timer, bit index and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic: bit timing and sampling of the synchronized line
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (!rx_s) begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                    end else begin
                        // Line went back high before mid start bit: glitch
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = CNT_ZERO;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        // A held-low line (break) must not start a new frame
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_HIGH;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
                idx_d   = 3'd0;
            end
        endcase
    end

    // Frame-level events decoded from the receiver state at the stop sample
    always_comb begin
        byte_done_s = 1'b0;
        stop_bad_s  = 1'b0;
        case (state_q)
            STOP: begin
                byte_done_s = (cnt_q == BIT_LAST) &&  rx_s;
                stop_bad_s  = (cnt_q == BIT_LAST) && !rx_s;
            end
            default: begin
                byte_done_s = 1'b0;
                stop_bad_s  = 1'b0;
            end
        endcase
    end

    // Holding register, overrun and framing-error next values
    always_comb begin
        consume_s    = data_valid_q & data_ready;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        drop_s       = 1'b0;
        if (byte_done_s) begin
            if (!data_valid_q || consume_s) begin
                data_out_d   = shift_q;
                data_valid_d = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else if (consume_s) begin
            data_valid_d = 1'b0;
        end else begin
            data_valid_d = data_valid_q;
        end
        // A new drop wins over a simultaneous clear
        overrun_d   = (overrun_q & ~err_clr) | drop_s;
        frame_err_d = stop_bad_s;
    end

    // Registered outputs towards the core
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend at 8 clocks per bit: directed scenarios with
// literal expectations plus a randomized run, all checked every cycle
// against a timing-based reference model of the receiver.
`timescale 1ns/1ps
module tb_uart_rx_frontend;

    localparam int C    = 8;
    localparam int HALF = C / 2;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       rx_in      = 1'b1;
    logic       err_clr    = 1'b0;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    bit         m_s1     = 1'b1;
    bit         m_s2     = 1'b1;
    bit         m_active = 1'b0;
    bit         m_wait   = 1'b0;
    int         m_start  = 0;
    logic [7:0] m_byte   = 8'h00;
    logic [7:0] m_data   = 8'h00;
    bit         m_valid  = 1'b0;
    bit         m_over   = 1'b0;
    bit         m_ferr   = 1'b0;
    bit         rand_on  = 1'b0;

    always #5 clk = ~clk;

    uart_rx_frontend #(
        .CLKS_PER_BIT (C)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .err_clr    (err_clr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: the line value seen at an edge is rx_in from two edges earlier;
    // a frame that starts being seen at edge S is judged purely from
    // offsets: start check at S+HALF, bit k at S+HALF+(k+1)*C, stop at S+HALF+9*C.
    task automatic model_step();
        bit rxs;
        bit done;
        bit fe;
        bit consume;
        bit drop;
        int off;
        rxs = m_s2;
        if (rst) begin
            m_s1 = 1'b1; m_s2 = 1'b1;
            m_active = 1'b0; m_wait = 1'b0;
            m_byte = 8'h00; m_data = 8'h00;
            m_valid = 1'b0; m_over = 1'b0; m_ferr = 1'b0;
            return;
        end
        m_s2 = m_s1;
        m_s1 = rx_in;
        done = 1'b0;
        fe   = 1'b0;
        if (m_active) begin
            off = cyc - m_start;
            if (off == HALF) begin
                if (rxs) m_active = 1'b0;
            end else if (off == HALF + 9 * C) begin
                m_active = 1'b0;
                if (rxs) done = 1'b1;
                else begin
                    fe     = 1'b1;
                    m_wait = 1'b1;
                end
            end else if (off > HALF && ((off - HALF) % C) == 0) begin
                m_byte[(off - HALF) / C - 1] = rxs;
            end
        end else if (m_wait) begin
            if (rxs) m_wait = 1'b0;
        end else if (!rxs) begin
            m_active = 1'b1;
            m_start  = cyc;
        end
        consume = m_valid && data_ready;
        drop    = 1'b0;
        if (done) begin
            if (!m_valid || consume) begin
                m_data  = m_byte;
                m_valid = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (consume) begin
            m_valid = 1'b0;
        end
        m_over = (m_over && !err_clr) || drop;
        m_ferr = fe;
    endtask

    // Advance the edge counter and the model on every active edge
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
        end
    end

    // Compare DUT against the model on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                chk("cyc_data_valid", {31'd0, data_valid}, {31'd0, m_valid});
                chk("cyc_data_out",   {24'd0, data_out},   {24'd0, m_data});
                chk("cyc_frame_err",  {31'd0, frame_err},  {31'd0, m_ferr});
                chk("cyc_overrun",    {31'd0, overrun},    {31'd0, m_over});
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    // Drive one 8N1 frame starting on a falling edge
    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        rx_in = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (C) @(negedge clk);
        end
        rx_in = stop_val;
        repeat (C) @(negedge clk);
    endtask

    // Wait for data_valid (sel=0) or frame_err (sel=1) to rise; report edge and width
    task automatic wait_flag(input bit sel, input int budget, output int edge_no, output int width);
        edge_no = -1;
        width   = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((sel ? frame_err : data_valid) === 1'b1) begin
                edge_no = cyc;
                break;
            end
        end
        if (edge_no >= 0) begin
            width = 1;
            for (int i = 0; i < budget; i++) begin
                @(negedge clk);
                if ((sel ? frame_err : data_valid) !== 1'b1) break;
                width++;
            end
        end
    endtask

    initial begin
        int  t0;
        int  e;
        int  w;
        bit  seen;
        logic [7:0] b;
        bit  stop_ok;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_data_out",   {24'd0, data_out},   32'd0);
        chk("rst_frame_err",  {31'd0, frame_err},  32'd0);
        chk("rst_overrun",    {31'd0, overrun},    32'd0);
        repeat (4) @(negedge clk);

        // 1: 0xA5 with the core ready
        data_ready = 1'b1;
        t0 = cyc + 1;
        fork
            send_byte(8'hA5, 1'b1);
            wait_flag(1'b0, 200, e, w);
        join
        chk("s1_latency", e - t0, 32'd78);
        chk("s1_width", w, 32'd1);
        chk("s1_data", {24'd0, data_out}, 32'h0000_00A5);
        chk("s1_model_data", {24'd0, m_data}, 32'h0000_00A5);
        chk("s1_overrun", {31'd0, overrun}, 32'd0);
        repeat (4) @(negedge clk);

        // 2: two-cycle low glitch on an idle line
        rx_in = 1'b0;
        repeat (2) @(negedge clk);
        rx_in = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            seen = seen | data_valid | frame_err;
        end
        chk("s2_quiet", {31'd0, seen}, 32'd0);

        // 3: 0x3C with a low stop bit, line held low afterwards
        t0 = cyc + 1;
        fork
            begin
                send_byte(8'h3C, 1'b0);
                repeat (20) @(negedge clk);
            end
            wait_flag(1'b1, 200, e, w);
        join
        chk("s3_latency", e - t0, 32'd78);
        chk("s3_width", w, 32'd1);
        chk("s3_no_valid", {31'd0, data_valid}, 32'd0);
        chk("s3_model_wait", {31'd0, m_wait}, 32'd1);
        rx_in = 1'b1;
        repeat (2 * C) @(negedge clk);

        // 4: core stalled, two back-to-back frames
        data_ready = 1'b0;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        chk("s4_data", {24'd0, data_out}, 32'h0000_0011);
        chk("s4_valid", {31'd0, data_valid}, 32'd1);
        chk("s4_overrun", {31'd0, overrun}, 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        chk("s4_clr", {31'd0, overrun}, 32'd0);

        // 5: consume 0x11 in exactly the cycle 0x22 completes
        t0 = cyc + 1;
        fork
            send_byte(8'h22, 1'b1);
            begin
                repeat (78) @(negedge clk);
                data_ready = 1'b1;
                @(negedge clk);
                data_ready = 1'b0;
                chk("s5_data", {24'd0, data_out}, 32'h0000_0022);
                chk("s5_valid", {31'd0, data_valid}, 32'd1);
                chk("s5_overrun", {31'd0, overrun}, 32'd0);
            end
        join
        data_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("s5_drained", {31'd0, data_valid}, 32'd0);

        // 6: reset during data bit 4, then a clean 0x5A
        fork
            send_byte(8'hF0, 1'b1);
            begin
                repeat (5 * C + 2) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("s6_rst_valid", {31'd0, data_valid}, 32'd0);
                chk("s6_rst_data",  {24'd0, data_out},   32'd0);
                chk("s6_rst_ferr",  {31'd0, frame_err},  32'd0);
                chk("s6_rst_over",  {31'd0, overrun},    32'd0);
                seen = 1'b0;
                repeat (60) begin
                    @(negedge clk);
                    seen = seen | data_valid | frame_err;
                end
                chk("s6_no_delivery", {31'd0, seen}, 32'd0);
            end
        join
        t0 = cyc + 1;
        fork
            send_byte(8'h5A, 1'b1);
            wait_flag(1'b0, 200, e, w);
        join
        chk("s6_latency", e - t0, 32'd78);
        chk("s6_data", {24'd0, data_out}, 32'h0000_005A);
        repeat (4) @(negedge clk);

        // Randomized frames, glitches, back-pressure and error clears
        rand_on = 1'b1;
        fork
            begin
                for (int f = 0; f < 40; f++) begin
                    b       = 8'($urandom);
                    stop_ok = ($urandom_range(0, 7) != 0);
                    if ($urandom_range(0, 9) == 0) begin
                        rx_in = 1'b0;
                        repeat ($urandom_range(1, 3)) @(negedge clk);
                        rx_in = 1'b1;
                        repeat (C) @(negedge clk);
                    end
                    send_byte(b, stop_ok);
                    if (!stop_ok) begin
                        repeat ($urandom_range(0, 12)) @(negedge clk);
                        rx_in = 1'b1;
                    end
                    repeat ($urandom_range(0, C)) @(negedge clk);
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(negedge clk);
                    data_ready = ($urandom_range(0, 2) == 0);
                    err_clr    = ($urandom_range(0, 19) == 0);
                end
            end
        join

        rx_in      = 1'b1;
        err_clr    = 1'b0;
        data_ready = 1'b1;
        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Serial byte receiver that sits directly upstream of the tt_um_ashergistcrazy core. It takes the asynchronous 8N1 UART line from a dedicated input pin, oversamples it with the system clock, and delivers each received byte to the core over a valid/ready handshake. A one-entry holding register absorbs core back-pressure, and framing and overrun errors are flagged.

## Interface
- CLKS_PER_BIT, 87 — clock cycles per UART bit (10 MHz / 115200); legal range 4–65535
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx_in  in  1  asynchronous UART line, idle high (driven from ui_in[0])
- err_clr  in  1  single-cycle pulse; clears the sticky overrun flag
- data_out  out  8  received byte, stable while data_valid=1
- data_valid  out  1  holding register full
- data_ready  in  1  core accepts data_out when data_valid & data_ready
- frame_err  out  1  one-cycle pulse: the stop bit sampled low
- overrun  out  1  sticky: a completed byte was dropped because the holding register was full

## Operation
- rx_in passes through a 2-flop synchronizer to give rx_s. Both flops reset to 1.
- Constants: HALF = CLKS_PER_BIT/2 (integer division). The bit counter cnt is $clog2(CLKS_PER_BIT) bits wide. The bit index is 3 bits.
- FSM states are IDLE, START, DATA, STOP, WAIT_HIGH. Reset state is IDLE.
- IDLE: rx_s=0 moves to START with cnt=0.
- START: increments cnt until cnt==HALF-1. At that point:
  - rx_s=0 moves to DATA with cnt=0 and idx=0.
  - rx_s=1 is a glitch; return to IDLE with no output.
- DATA: increments cnt until cnt==CLKS_PER_BIT-1. At that point:
  - shift[idx] <= rx_s (LSB first), cnt=0.
  - idx==7 moves to STOP; otherwise idx++.
- STOP: increments cnt until cnt==CLKS_PER_BIT-1. At that point:
  - rx_s=1: the byte is complete; go to IDLE.
  - rx_s=0: pulse frame_err, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stays until rx_s=1, then goes to IDLE. A break condition therefore never retriggers a receive.
- Holding register, on a byte-complete event:
  - Empty, or being consumed this cycle (data_valid & data_ready): load data_out and set data_valid=1.
  - Full and not consumed: keep the old byte, drop the new one, set overrun=1.
- Consume without completion: data_valid clears on the edge where data_valid & data_ready.
- overrun clears only on err_clr or rst. If err_clr and a new overrun occur in the same cycle, overrun stays 1.
- Reset values:
  - data_out=0, data_valid=0, frame_err=0, overrun=0.
  - FSM state IDLE, cnt=0, idx=0, shift=0.
- rst asserted mid-frame aborts immediately, with no partial delivery.

## Timing
- Define t0 as the edge at which the first low rx_in is captured by sync flop 1.
- IDLE sees rx_s=0 at edge t0+2.
- Start-bit check happens at edge t0+2+HALF.
- Data bit k is sampled at edge t0+2+HALF+(k+1)·CLKS_PER_BIT.
- Stop bit is sampled at edge t0+2+HALF+9·CLKS_PER_BIT. data_valid (or frame_err) is high from that edge.
- Back-to-back frames are supported: a start bit is detected within 1 cycle of returning to IDLE.
- The handshake is combinationally independent: data_valid never depends on data_ready in the same cycle.

## Structure
- Shared package uart_pkg holds:
  - the state enum rx_state_t {IDLE, START, DATA, STOP, WAIT_HIGH}
  - the localparam DEFAULT_CLKS_PER_BIT = 87
- One sub-module, sync_2ff: a 1-bit, 2-flop synchronizer with a reset value parameter. The same sub-module is reused for other pin inputs.
- The holding register and FSM live in uart_rx_frontend.

## Test plan
(All scenarios use CLKS_PER_BIT=8, HALF=4.)
- Send 0xA5 with data_ready=1 → data_valid rises at t0+78 with data_out=0xA5; it is high for 1 cycle; frame_err=0, overrun=0.
- Low glitch of 2 cycles on idle rx_in → FSM returns to IDLE, data_valid stays 0, frame_err stays 0.
- Send 0x3C with stop bit forced low, held low 20 more cycles → frame_err pulses 1 cycle at t0+78, no data_valid, no new receive until rx_in returns high.
- data_ready=0; send 0x11 then 0x22 back-to-back → data_out stays 0x11 and data_valid stays 1; overrun=1 after the second stop bit. Then err_clr → overrun=0.
- data_ready=0 while 0x11 is held; raise data_ready in exactly the cycle 0x22 completes → data_out=0x22, data_valid stays 1, overrun=0.
- Assert rst at bit 4 of a frame → all outputs 0 next cycle, no byte delivered. The next clean frame 0x5A is received correctly.
